// File: rtl/alu_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Brief    : Shared types and constants for the ALU command sequencer:
//             opcode encoding, FSM state encoding, divide-by-zero result.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // ALU opcode encoding as seen on cmd_op / alu_opcode
  typedef enum logic [2:0] {
    OP_ADDC = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOD  = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_ADD  = 3'd7
  } op_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Result returned for a suppressed divide/modulo by zero
  localparam logic [63:0] DIV0_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Brief    : Initiator for a combinational 32-bit ALU. Accepts one command
//             at a time on a valid/ready stream, holds the ALU inputs for
//             SETTLE_CYC+1 cycles, captures the 64-bit result and returns it
//             with its tag on a valid/ready response stream.
//  Options  : ALU_DIV_ZERO_CHECK_EN - when defined, divide/modulo by zero is
//             answered directly with an all-ones result and rsp_err=1 without
//             touching the ALU inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // command stream
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_cin,
  input  logic [TAG_W-1:0] cmd_tag,
  // ALU side
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [63:0]      alu_out,
  // response stream
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYC);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [2:0]       alu_op_q;
  logic             alu_cin_q;
  logic [63:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic             rsp_valid_q;

  logic             w_div0;
  logic             w_cin_d;

  // Divide/modulo by zero is only intercepted when the check is built in
`ifdef ALU_DIV_ZERO_CHECK_EN
  assign w_div0 = ((cmd_op == OP_DIV) || (cmd_op == OP_MOD)) && (cmd_b == 32'd0);
`else
  assign w_div0 = 1'b0;
`endif

  // Carry-in only reaches the ALU for the add-with-carry opcode
  assign w_cin_d = (cmd_op == OP_ADDC) ? cmd_cin : 1'b0;

  // Command/response FSM with settle counter and registered ALU/response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_op_q    <= 3'd0;
      alu_cin_q   <= 1'b0;
      rsp_data_q  <= 64'd0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            rsp_tag_q <= cmd_tag;
            if (w_div0) begin
              // Answered locally; ALU inputs keep their previous values
              rsp_data_q  <= DIV0_RESULT;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_op_q  <= cmd_op;
              alu_cin_q <= w_cin_d;
              rsp_err_q <= 1'b0;
              cnt_q     <= c_SETTLE_INIT;
              state_q   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= alu_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

endmodule : alu_cmd_sequencer
`default_nettype wire
